// File: rtl/mpt_pkg.sv
// Shared types and constants for the MPT table-walk memory arbiter.
package mpt_pkg;

    localparam int unsigned MPT_ARB_MAX_REQ = 3;

    typedef logic [$clog2(MPT_ARB_MAX_REQ)-1:0] mpt_arb_idx_t;

    function automatic int unsigned mpt_arb_wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/mpt_arb_id_fifo.sv
// Synchronous FIFO of granted requester indices, used to route in-order responses.
module mpt_arb_id_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_o == CNT_W'(DEPTH));
    assign empty_o = (count_o == '0);
    assign head_o  = mem[rd_ptr];
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is only legal when the same cycle frees a slot.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: rtl/mpt_walk_mem_arbiter.sv
// Round-robin arbiter sharing one memory master among the MPT walking stages.
// Optional MPT_ARB_STATS_EN adds per-requester saturating grant counters on grant_cnt_o.
module mpt_walk_mem_arbiter
    import mpt_pkg::*;
#(
    parameter int unsigned NUM_REQ         = MPT_ARB_MAX_REQ,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              s_mem_req,
    output logic [NUM_REQ-1:0]              s_mem_gnt,
    output logic [NUM_REQ-1:0]              s_mem_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_mem_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_mem_wdata,
    input  logic [NUM_REQ-1:0]              s_mem_we,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_mem_be,
    output logic [DATA_WIDTH-1:0]           s_mem_rdata,
    output logic [NUM_REQ-1:0]              s_mem_error,
    output logic                            m_mem_req,
    input  logic                            m_mem_gnt,
    input  logic                            m_mem_valid,
    output logic [ADDR_WIDTH-1:0]           m_mem_addr,
    output logic [DATA_WIDTH-1:0]           m_mem_wdata,
    output logic                            m_mem_we,
    output logic [DATA_WIDTH/8-1:0]         m_mem_be,
    input  logic [DATA_WIDTH-1:0]           m_mem_rdata,
    input  logic                            m_mem_error,
    output logic                            spurious_rsp_o
`ifdef MPT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]           grant_cnt_o
`endif
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic             lock_valid;
    logic [IDX_W-1:0] arb_idx;
    logic             any_req;
    logic [IDX_W-1:0] sel;
    logic             sel_req;
    logic             hs;
    logic             pop;
    logic [IDX_W-1:0] head_idx;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // First active requester scanning upward from rr_ptr, wrapping mod NUM_REQ.
    always_comb begin
        logic [IDX_W:0] cand;
        cand    = '0;
        any_req = 1'b0;
        arb_idx = rr_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!any_req && s_mem_req[cand[IDX_W-1:0]]) begin
                any_req = 1'b1;
                arb_idx = cand[IDX_W-1:0];
            end
        end
    end

    // A stalled request keeps its requester until granted, so the master sees stable fields.
    assign sel       = lock_valid ? lock_idx : arb_idx;
    assign sel_req   = lock_valid ? s_mem_req[lock_idx] : any_req;
    assign m_mem_req = ~rst_i & ~fifo_full & sel_req;
    assign hs        = m_mem_req & m_mem_gnt;
    assign pop       = m_mem_valid & ~fifo_empty;
    assign s_mem_rdata = m_mem_rdata;

    always_comb begin
        m_mem_addr  = '0;
        m_mem_wdata = '0;
        m_mem_we    = 1'b0;
        m_mem_be    = '0;
        s_mem_gnt   = '0;
        s_mem_valid = '0;
        s_mem_error = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel == IDX_W'(i)) begin
                m_mem_addr   = s_mem_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_mem_wdata  = s_mem_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_mem_we     = s_mem_we[i];
                m_mem_be     = s_mem_be[i*BE_W +: BE_W];
                s_mem_gnt[i] = hs;
            end
            if (head_idx == IDX_W'(i)) begin
                s_mem_valid[i] = pop;
                s_mem_error[i] = pop & m_mem_error;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr         <= '0;
            lock_idx       <= '0;
            lock_valid     <= 1'b0;
            spurious_rsp_o <= 1'b0;
        end else begin
            if (m_mem_valid && fifo_count == '0) begin
                spurious_rsp_o <= 1'b1;
            end
            if (hs) begin
                lock_valid <= 1'b0;
                rr_ptr     <= IDX_W'(mpt_arb_wrap_inc(32'(sel), NUM_REQ));
            end else if (m_mem_req) begin
                lock_valid <= 1'b1;
                lock_idx   <= sel;
            end else if (lock_valid && !s_mem_req[lock_idx]) begin
                // Withdrawn requester must not block the others forever.
                lock_valid <= 1'b0;
            end
        end
    end

    mpt_arb_id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (hs),
        .push_data_i (sel),
        .pop_i       (pop),
        .head_o      (head_idx),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

`ifdef MPT_ARB_STATS_EN
    logic [31:0] grant_cnt [NUM_REQ];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (s_mem_gnt[i] && grant_cnt[i] != '1) begin
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_cnt_o[i*32 +: 32] = grant_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_mpt_walk_mem_arbiter.sv
// Directed self-checking bench for mpt_walk_mem_arbiter (3 requesters, 4 outstanding).
module tb_mpt_walk_mem_arbiter;
    import mpt_pkg::*;

    logic          clk;
    logic          rst;
    logic [2:0]    s_req;
    logic [2:0]    s_gnt;
    logic [2:0]    s_valid;
    logic [191:0]  s_addr;
    logic [191:0]  s_wdata;
    logic [2:0]    s_we;
    logic [23:0]   s_be;
    logic [63:0]   s_rdata;
    logic [2:0]    s_error;
    logic          m_req;
    logic          m_gnt;
    logic          m_valid;
    logic [63:0]   m_addr;
    logic [63:0]   m_wdata;
    logic          m_we;
    logic [7:0]    m_be;
    logic [63:0]   m_rdata;
    logic          m_error;
    logic          spurious;
`ifdef MPT_ARB_STATS_EN
    logic [95:0]   grant_cnt;
`endif

    int unsigned tests;
    int unsigned fails;

    mpt_walk_mem_arbiter #(
        .NUM_REQ         (3),
        .DATA_WIDTH      (64),
        .ADDR_WIDTH      (64),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .s_mem_req      (s_req),
        .s_mem_gnt      (s_gnt),
        .s_mem_valid    (s_valid),
        .s_mem_addr     (s_addr),
        .s_mem_wdata    (s_wdata),
        .s_mem_we       (s_we),
        .s_mem_be       (s_be),
        .s_mem_rdata    (s_rdata),
        .s_mem_error    (s_error),
        .m_mem_req      (m_req),
        .m_mem_gnt      (m_gnt),
        .m_mem_valid    (m_valid),
        .m_mem_addr     (m_addr),
        .m_mem_wdata    (m_wdata),
        .m_mem_we       (m_we),
        .m_mem_be       (m_be),
        .m_mem_rdata    (m_rdata),
        .m_mem_error    (m_error),
        .spurious_rsp_o (spurious)
`ifdef MPT_ARB_STATS_EN
        ,
        .grant_cnt_o    (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_req   = '0;
        m_gnt   = 1'b0;
        m_valid = 1'b0;
        m_rdata = '0;
        m_error = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        s_addr  = {64'h3000, 64'h2000, 64'h1000};
        s_wdata = {64'hC2, 64'hB1, 64'hA0};
        s_we    = 3'b101;
        s_be    = {8'hF0, 8'h0F, 8'hFF};
        rst = 1'b1;
        clear_inputs();
        #1;
        chk("rst_m_req", 64'(m_req), 64'd0);
        chk("rst_s_gnt", 64'(s_gnt), 64'd0);
        chk("rst_s_valid", 64'(s_valid), 64'd0);
        chk("rst_spurious", 64'(spurious), 64'd0);
        tick();
        rst = 1'b0;
        #1;

        // 1) single requester, response two cycles after grant
        s_req = 3'b001; m_gnt = 1'b1;
        #1;
        chk("t1_m_req", 64'(m_req), 64'd1);
        chk("t1_gnt", 64'(s_gnt), 64'b001);
        chk("t1_addr", m_addr, 64'h1000);
        chk("t1_wdata", m_wdata, 64'hA0);
        chk("t1_we", 64'(m_we), 64'd1);
        chk("t1_be", 64'(m_be), 64'hFF);
        tick();
        s_req = 3'b000; m_gnt = 1'b0;
        #1;
        chk("t1_no_valid", 64'(s_valid), 64'd0);
        tick();
        m_valid = 1'b1; m_rdata = 64'hDEAD;
        #1;
        chk("t1_valid", 64'(s_valid), 64'b001);
        chk("t1_rdata", s_rdata, 64'hDEAD);
        tick();
        m_valid = 1'b0;

        // 2) all requesting, grant always: rotation 0,1,2,0,1,2 with responses following
        do_reset();
        s_req = 3'b111; m_gnt = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            m_valid = (k > 0);
            #1;
            chk("t2_gnt", 64'(s_gnt), 64'(1) << (k % 3));
            if (k > 0) chk("t2_valid", 64'(s_valid), 64'(1) << ((k - 1) % 3));
            tick();
        end
        s_req = 3'b000; m_gnt = 1'b0; m_valid = 1'b1;
        #1;
        chk("t2_last_valid", 64'(s_valid), 64'b100);
        chk("t2_idle_req", 64'(m_req), 64'd0);
        tick();
        m_valid = 1'b0;

        // 3) stalled request is locked against a later requester
        do_reset();
        s_req = 3'b010; m_gnt = 1'b0;
        #1;
        chk("t3_req", 64'(m_req), 64'd1);
        chk("t3_addr0", m_addr, 64'h2000);
        tick();
        s_req = 3'b011;
        #1;
        chk("t3_addr1", m_addr, 64'h2000);
        chk("t3_nogrant", 64'(s_gnt), 64'd0);
        tick();
        #1;
        chk("t3_addr2", m_addr, 64'h2000);
        tick();
        m_gnt = 1'b1;
        #1;
        chk("t3_gnt1", 64'(s_gnt), 64'b010);
        chk("t3_addr3", m_addr, 64'h2000);
        tick();
        s_req = 3'b001;
        #1;
        chk("t3_gnt0", 64'(s_gnt), 64'b001);
        chk("t3_addr4", m_addr, 64'h1000);
        tick();

        // 4) FIFO full blocks the 5th request until a response frees a slot
        do_reset();
        s_req = 3'b001; m_gnt = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            #1;
            chk("t4_fill", 64'(s_gnt), 64'b001);
            tick();
        end
        #1;
        chk("t4_full_req", 64'(m_req), 64'd0);
        chk("t4_full_gnt", 64'(s_gnt), 64'd0);
        tick();
        m_valid = 1'b1;
        #1;
        chk("t4_pop_valid", 64'(s_valid), 64'b001);
        chk("t4_pop_noreq", 64'(m_req), 64'd0);
        tick();
        m_valid = 1'b0;
        #1;
        chk("t4_after_req", 64'(m_req), 64'd1);
        chk("t4_after_gnt", 64'(s_gnt), 64'b001);
        tick();

        // 5) grant to req2 coincides with response for req0
        do_reset();
        s_req = 3'b001; m_gnt = 1'b1;
        #1;
        chk("t5_gnt0", 64'(s_gnt), 64'b001);
        tick();
        s_req = 3'b100; m_valid = 1'b1;
        #1;
        chk("t5_gnt2", 64'(s_gnt), 64'b100);
        chk("t5_valid0", 64'(s_valid), 64'b001);
        tick();
        s_req = 3'b000; m_gnt = 1'b0; m_error = 1'b1;
        #1;
        chk("t5_head2_valid", 64'(s_valid), 64'b100);
        chk("t5_head2_error", 64'(s_error), 64'b100);
        tick();
        m_valid = 1'b0; m_error = 1'b0;
        #1;
        chk("t5_no_spurious", 64'(spurious), 64'd0);

        // 6) spurious response is sticky; reset mid-burst clears everything
        do_reset();
        m_valid = 1'b1;
        #1;
        chk("t6_drop", 64'(s_valid), 64'd0);
        tick();
        m_valid = 1'b0;
        #1;
        chk("t6_spurious", 64'(spurious), 64'd1);
        tick();
        #1;
        chk("t6_sticky", 64'(spurious), 64'd1);
        s_req = 3'b111; m_gnt = 1'b1;
        #1;
        chk("t6_burst0", 64'(s_gnt), 64'b001);
        tick();
        #1;
        chk("t6_burst1", 64'(s_gnt), 64'b010);
        tick();
        m_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("t6_rst_req", 64'(m_req), 64'd0);
        chk("t6_rst_gnt", 64'(s_gnt), 64'd0);
        chk("t6_rst_valid", 64'(s_valid), 64'd0);
        chk("t6_rst_spurious", 64'(spurious), 64'd0);
        rst = 1'b0; s_req = 3'b000; m_gnt = 1'b0;
        #1;
        chk("t6_empty_valid", 64'(s_valid), 64'd0);
        tick();
        m_valid = 1'b0;
        #1;
        chk("t6_empty_spurious", 64'(spurious), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
